// File: rtl/fifo_read_ctrl.sv
// Read-side controller for a synchronous FIFO: owns the read pointer, issues
// memory reads and presents words through a two-entry head/skid output stage.
module fifo_read_ctrl #(
   parameter int SIZE      = 4,
   parameter int WIDTH     = 8,
   parameter int AE_THRESH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE:0]   w_pointer,
   output logic [SIZE:0]   r_pointer,
   output logic            rd_en,
   output logic [SIZE-1:0] rd_addr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic [WIDTH-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            empty,
   output logic [SIZE:0]   count,
   output logic            ae_flag
);

   logic [SIZE:0]    r_pointer_reg, r_pointer_next;
   logic             inflight_reg, inflight_next;
   logic [WIDTH-1:0] head_reg, head_next;
   logic             head_valid_reg, head_valid_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             skid_valid_reg, skid_valid_next;

   logic             fire;
   logic [1:0]       occ;
   logic [1:0]       occ_after_fire;
   logic [SIZE+1:0]  total;

   assign fire           = head_valid_reg & dout_ready;
   assign occ            = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, inflight_reg};
   // fire implies a valid head, so this never underflows
   assign occ_after_fire = occ - {1'b0, fire};

   assign count   = w_pointer - r_pointer_reg;
   assign empty   = (w_pointer == r_pointer_reg);
   assign rd_en   = !empty && (occ_after_fire < 2'd2);
   assign total   = {1'b0, count} + {{SIZE{1'b0}}, occ};
   assign ae_flag = (total <= (SIZE+2)'(AE_THRESH));

   assign r_pointer  = r_pointer_reg;
   assign rd_addr    = r_pointer_reg[SIZE-1:0];
   assign dout       = head_reg;
   assign dout_valid = head_valid_reg;

   always_comb begin
      r_pointer_next  = r_pointer_reg;
      inflight_next   = rd_en;
      head_next       = head_reg;
      head_valid_next = head_valid_reg;
      skid_next       = skid_reg;
      skid_valid_next = skid_valid_reg;

      if (rd_en) begin
         r_pointer_next = r_pointer_reg + 1'b1;
      end

      if (fire) begin
         if (skid_valid_reg) begin
            head_next       = skid_reg;
            skid_valid_next = inflight_reg;
            if (inflight_reg) begin
               skid_next = mem_rdata;
            end
         end else if (inflight_reg) begin
            head_next = mem_rdata;
         end else begin
            // head drained; data is held, only the valid drops
            head_valid_next = 1'b0;
         end
      end else if (inflight_reg) begin
         if (!head_valid_reg) begin
            head_next       = mem_rdata;
            head_valid_next = 1'b1;
         end else begin
            skid_next       = mem_rdata;
            skid_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pointer_reg  <= '0;
         inflight_reg   <= 1'b0;
         head_reg       <= '0;
         head_valid_reg <= 1'b0;
         skid_reg       <= '0;
         skid_valid_reg <= 1'b0;
      end else begin
         r_pointer_reg  <= r_pointer_next;
         inflight_reg   <= inflight_next;
         head_reg       <= head_next;
         head_valid_reg <= head_valid_next;
         skid_reg       <= skid_next;
         skid_valid_reg <= skid_valid_next;
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a behavioural synchronous-read memory.
module tb_fifo_read_ctrl;

   localparam int SIZE  = 4;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [SIZE:0]    w_pointer;
   logic [SIZE:0]    r_pointer;
   logic             rd_en;
   logic [SIZE-1:0]  rd_addr;
   logic [WIDTH-1:0] mem_rdata = '0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             empty;
   logic [SIZE:0]    count;
   logic             ae_flag;

   logic [WIDTH-1:0] mem [0:(1<<SIZE)-1];

   int pass_cnt  = 0;
   int check_cnt = 0;

   fifo_read_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .AE_THRESH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .w_pointer  (w_pointer),
      .r_pointer  (r_pointer),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .mem_rdata  (mem_rdata),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .empty      (empty),
      .count      (count),
      .ae_flag    (ae_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) mem_rdata <= mem[rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %s got %0h", tag, got);
      end else begin
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_rd;
      int n_out;
      int n_exp;

      rst        = 1'b1;
      w_pointer  = '0;
      dout_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      tick();

      // reset state
      check("rst_rptr",   32'(r_pointer), 0);
      check("rst_valid",  32'(dout_valid), 0);
      check("rst_dout",   32'(dout), 0);
      check("rst_empty",  32'(empty), 1);
      check("rst_count",  32'(count), 0);
      check("rst_ae",     32'(ae_flag), 1);
      check("rst_rden",   32'(rd_en), 0);

      rst = 1'b0;
      tick();
      tick();

      // single word
      mem[0]     = 8'hA5;
      dout_ready = 1'b1;
      w_pointer  = 5'd1;
      #1;
      check("sw_empty",   32'(empty), 0);
      check("sw_rden",    32'(rd_en), 1);
      check("sw_addr",    32'(rd_addr), 0);
      tick();
      check("sw_rden2",   32'(rd_en), 0);
      check("sw_valid1",  32'(dout_valid), 0);
      tick();
      check("sw_valid2",  32'(dout_valid), 1);
      check("sw_dout",    32'(dout), 32'hA5);
      tick();
      check("sw_valid3",  32'(dout_valid), 0);
      check("sw_hold",    32'(dout), 32'hA5);
      check("sw_empty2",  32'(empty), 1);
      check("sw_ae",      32'(ae_flag), 1);

      // reset mid-stream with head and skid both full
      dout_ready = 1'b0;
      for (int i = 1; i <= 4; i++) mem[i] = 8'h10 + 8'(i);
      w_pointer = 5'd5;
      for (int i = 0; i < 4; i++) tick();
      check("bp_rptr",    32'(r_pointer), 3);
      check("bp_rden",    32'(rd_en), 0);
      check("bp_dout",    32'(dout), 32'h11);
      check("bp_count",   32'(count), 2);
      check("bp_ae",      32'(ae_flag), 0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rptr",   32'(r_pointer), 0);
      check("mid_valid",  32'(dout_valid), 0);
      check("mid_dout",   32'(dout), 0);
      w_pointer = '0;
      #1;
      check("mid_empty",  32'(empty), 1);
      check("mid_count",  32'(count), 0);
      check("mid_ae",     32'(ae_flag), 1);
      check("mid_rden",   32'(rd_en), 0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("post_rden",  32'(rd_en), 0);
      check("post_valid", 32'(dout_valid), 0);

      // streaming 16 words from a full memory
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
      dout_ready = 1'b1;
      w_pointer  = 5'b10000;
      #1;
      check("st_count",   32'(count), 16);
      check("st_empty",   32'(empty), 0);
      for (int i = 0; i < 5 && !dout_valid; i++) tick();
      for (int i = 0; i < 16; i++) begin
         check($sformatf("st_valid%0d", i), 32'(dout_valid), 1);
         check($sformatf("st_dout%0d", i), 32'(dout), 32'(i));
         tick();
      end
      check("st_rptr",    32'(r_pointer), 16);
      check("st_empty2",  32'(empty), 1);
      check("st_valid_end", 32'(dout_valid), 0);

      // backpressure: 16 words, consumer stalled 10 cycles
      for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
      dout_ready = 1'b0;
      w_pointer  = 5'd0;
      #1;
      n_rd = 0;
      for (int i = 0; i < 10; i++) begin
         if (rd_en) n_rd++;
         tick();
      end
      check("bk_reads",   32'(n_rd), 2);
      check("bk_count",   32'(count), 14);
      check("bk_dout",    32'(dout), 32'h40);
      check("bk_valid",   32'(dout_valid), 1);
      check("bk_rden",    32'(rd_en), 0);
      dout_ready = 1'b1;
      n_out = 0;
      for (int i = 0; i < 40 && n_out < 16; i++) begin
         if (dout_valid) begin
            check($sformatf("bk_dout%0d", n_out), 32'(dout), 32'h40 + 32'(n_out));
            n_out++;
         end
         tick();
      end
      check("bk_nout",    32'(n_out), 16);
      check("bk_rptr",    32'(r_pointer), 0);
      check("bk_empty",   32'(empty), 1);

      // move read pointer to 12, then full/wrap
      w_pointer = 5'd12;
      for (int i = 0; i < 20; i++) tick();
      check("wr_rptr12",  32'(r_pointer), 12);
      for (int k = 0; k < 16; k++) mem[(12 + k) % 16] = 8'h80 + 8'(k);
      w_pointer = 5'd28;
      #1;
      check("wr_count",   32'(count), 16);
      check("wr_empty",   32'(empty), 0);
      n_rd  = 0;
      n_out = 0;
      for (int i = 0; i < 60 && n_out < 16; i++) begin
         if (rd_en) begin
            check($sformatf("wr_addr%0d", n_rd), 32'(rd_addr), 32'((12 + n_rd) % 16));
            check($sformatf("wr_rptr%0d", n_rd), 32'(r_pointer), 32'((12 + n_rd) % 32));
            n_rd++;
         end
         if (dout_valid) begin
            check($sformatf("wr_dout%0d", n_out), 32'(dout), 32'h80 + 32'(n_out));
            n_out++;
         end
         tick();
      end
      check("wr_nrd",     32'(n_rd), 16);
      check("wr_nout",    32'(n_out), 16);
      check("wr_rptr_end", 32'(r_pointer), 28);

      // almost-empty while draining from total 4
      for (int k = 0; k < 4; k++) mem[(28 + k) % 16] = 8'hC0 + 8'(k);
      dout_ready = 1'b0;
      w_pointer  = 5'd0;
      for (int i = 0; i < 5; i++) tick();
      check("ae_count4",  32'(count), 2);
      check("ae_t4",      32'(ae_flag), 0);
      dout_ready = 1'b1;
      #1;
      check("ae_t4b",     32'(ae_flag), 0);
      tick();
      check("ae_t3",      32'(ae_flag), 0);
      check("ae_dout1",   32'(dout), 32'hC1);
      tick();
      check("ae_t2",      32'(ae_flag), 1);
      check("ae_dout2",   32'(dout), 32'hC2);
      tick();
      check("ae_t1",      32'(ae_flag), 1);
      check("ae_dout3",   32'(dout), 32'hC3);
      tick();
      check("ae_t0",      32'(ae_flag), 1);
      check("ae_valid0",  32'(dout_valid), 0);
      check("ae_empty",   32'(empty), 1);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's 16-entry synchronous FIFO. It consumes the write pointer from the write side and owns the read pointer. It drives the synchronous-read memory port and presents FIFO data on a valid/ready output interface. A two-entry output stage (head register plus skid register) sustains one word per cycle despite the memory's 1-cycle read latency. It also produces empty, occupancy and almost-empty status for downstream consumers.

## Interface
- SIZE, 4, address width; memory depth 2^SIZE; pointers are SIZE+1 bits (MSB = wrap bit)
- WIDTH, 8, data width
- AE_THRESH, 2, ae_flag asserts when total words held ≤ AE_THRESH
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- w_pointer  input  SIZE+1  write pointer from write side, same clock domain
- r_pointer  output  SIZE+1  read pointer, fed back to write side
- rd_en  output  1  memory read enable
- rd_addr  output  SIZE  memory read address = r_pointer[SIZE-1:0]
- mem_rdata  input  WIDTH  memory read data, valid the cycle after rd_en
- dout  output  WIDTH  head word
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  consumer accepts dout
- empty  output  1  memory holds no unread words (w_pointer == r_pointer)
- count  output  SIZE+1  w_pointer − r_pointer, modulo 2^(SIZE+1)
- ae_flag  output  1  almost-empty

## Operation
- fire = dout_valid & dout_ready.
- Registered state: r_pointer, inflight (read issued last cycle), dout/dout_valid (head), skid/skid_valid.
- occ = dout_valid + skid_valid + inflight, range 0..2.
- rd_en = !empty & (occ − fire < 2), combinational from registered state and dout_ready.
- On rd_en: r_pointer += 1 (wraps 2^(SIZE+1) → 0); inflight ← 1. Otherwise inflight ← 0.
- Return data when inflight = 1:
  - Goes to the head if the head is empty, or if the head fires while skid is empty.
  - Otherwise it goes to skid.
- On fire with skid_valid: skid moves to head, skid_valid ← 0, and returning data (if any) goes to skid.
- On fire with no skid and no return: dout_valid ← 0. dout is held, not cleared.
- dout and dout_valid are stable while dout_valid & !dout_ready.
- Order is preserved strictly: no word is lost or duplicated.
- count, empty, ae_flag are combinational from w_pointer and registered state.
  - total = count + occ.
  - ae_flag = (total ≤ AE_THRESH).
- Write side guarantees count ≤ 2^SIZE. Behaviour beyond that is undefined and not checked.
- Full (count = 2^SIZE, e.g. w_pointer = 5'b10000, r_pointer = 0): empty = 0, count = 16. Wrap bit distinguishes full from empty.

## Timing
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - r_pointer = 0, inflight = 0, dout = 0, dout_valid = 0, skid cleared.
  - rd_en = 0 while w_pointer = 0.
  - empty = 1, count = 0, ae_flag = 1 (with w_pointer = 0).
  - In-flight and buffered words are discarded.
- Latency: w_pointer increments at edge E. Then empty = 0 and rd_en = 1 in the cycle after E, and dout_valid = 1 after the next two edges (2 cycles).
- Throughput: with dout_ready held high and memory non-empty, one word per cycle after fill, and rd_en stays high.
- Backpressure: with dout_ready = 0, at most 2 reads are outstanding/buffered. rd_en drops once occ = 2.
- Simultaneous w_pointer increment and rd_en: count reflects both on the next cycle, net unchanged.
- rd_addr wraps 15 → 0 while r_pointer continues 15 → 16 (wrap bit set).

## Test plan
- Reset mid-stream:
  - Stimulus: assert rst with dout_valid = 1 and skid_valid = 1.
  - Response: all outputs return to reset values in the same cycle, with no clock edge needed.
  - After release with w_pointer = r_pointer, no spurious rd_en.
- Single word:
  - Stimulus: write 0xA5 (w_pointer 0 → 1), dout_ready = 1.
  - Response: rd_en = 1 for one cycle, rd_addr = 0; dout = 0xA5 with dout_valid 2 cycles after the pointer edge, for one cycle.
  - Afterwards empty = 1, ae_flag = 1.
- Streaming:
  - Stimulus: 16 words 0x00..0x0F preloaded (w_pointer = 16), dout_ready = 1.
  - Response: dout = 0x00..0x0F on 16 consecutive cycles, with no bubble after the first valid.
  - Final r_pointer = 16 (5'b10000), empty = 1.
- Backpressure:
  - Stimulus: 16 words, dout_ready = 0 for 10 cycles, then 1.
  - Response: exactly 2 reads issued; count = 14, total = 16, dout held at 0x00.
  - After release, the sequence continues in order without loss.
- Full/wrap:
  - Stimulus: r_pointer = 12, write 16 words.
  - Response: count = 16, empty = 0; rd_addr sequence 12, 13, 14, 15, 0, 1…; r_pointer passes 15 → 16 → 17.
- Almost-empty:
  - Stimulus: AE_THRESH = 2; drain from total 4 with dout_ready = 1.
  - Response: ae_flag = 0 at total 3, and 1 at total 2, 1 and 0.
